dispense_sequencer: RTL and testbench

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

---
 rtl/dispense_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_dispense_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_sequencer.sv
// dispense_sequencer
// Runs a sequence of dispense shots through an external dispense timer: each
// shot pulses timer_start, waits for dispense_sig to rise and fall, then
// either waits out the inter-shot gap or ends the sequence.
//
// Optional feature: define DISPENSE_SEQ_TIMEOUT_EN to abandon the sequence
// (sticky fault) when dispense_sig stays low for 8 cycles in WAIT_HI.
//
// Ports
//   FPGA_CLK1_50  in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   cmd_valid     in   command offered
//   cmd_ready     out  sequencer idle and accepting a command
//   cmd_duration  in   shot length in cycles (DUR_W)
//   cmd_gap       in   idle cycles between shots (GAP_W)
//   cmd_repeat    in   number of shots (CNT_W)
//   abort         in   level request to stop after the current shot
//   timer_value   out  latched duration to the dispense timer
//   timer_start   out  one-cycle start pulse to the dispense timer
//   dispense_sig  in   dispense timer output
//   busy          out  sequence in progress
//   shot_done     out  one-cycle pulse per completed shot
//   seq_done      out  one-cycle pulse at sequence end
//   shots_left    out  remaining shots
//   fault         out  sticky timeout flag, cleared by the next accept
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready=1
// START   | timer_start pulse for one shot
// WAIT_HI | waiting for dispense_sig to rise
// WAIT_LO | shot running, waiting for dispense_sig to fall
// GAP     | counting idle cycles between shots
// DONE    | seq_done pulse, back to IDLE next edge
module dispense_sequencer #(
  parameter int DUR_W = 31,
  parameter int GAP_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             FPGA_CLK1_50,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DUR_W-1:0] cmd_duration,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic [CNT_W-1:0] cmd_repeat,
  input  logic             abort,
  output logic [DUR_W-1:0] timer_value,
  output logic             timer_start,
  input  logic             dispense_sig,
  output logic             busy,
  output logic             shot_done,
  output logic             seq_done,
  output logic [CNT_W-1:0] shots_left,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO, S_GAP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] shots_q, shots_d;
  // An abort seen anywhere in a running shot must still end the sequence
  // after that shot, even if abort drops before the shot finishes.
  logic             abort_pend_q, abort_pend_d;
  logic             shot_end;
`ifdef DISPENSE_SEQ_TIMEOUT_EN
  logic [2:0]       to_cnt_q, to_cnt_d;
  logic             fault_q, fault_d;
`endif

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dur_q        <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      shots_q      <= '0;
      abort_pend_q <= 1'b0;
`ifdef DISPENSE_SEQ_TIMEOUT_EN
      to_cnt_q     <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      dur_q        <= dur_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      shots_q      <= shots_d;
      abort_pend_q <= abort_pend_d;
`ifdef DISPENSE_SEQ_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      fault_q      <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    dur_d        = dur_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    shots_d      = shots_q;
    abort_pend_d = abort_pend_q;
    shot_end     = 1'b0;
`ifdef DISPENSE_SEQ_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    fault_d      = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dur_d        = cmd_duration;
          gap_d        = cmd_gap;
          abort_pend_d = 1'b0;
`ifdef DISPENSE_SEQ_TIMEOUT_EN
          fault_d      = 1'b0;
`endif
          // A zero-length shot never raises dispense_sig, so nothing to run.
          if (cmd_repeat == '0 || cmd_duration == '0) begin
            shots_d = '0;
            state_d = S_DONE;
          end else begin
            shots_d = cmd_repeat;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        if (abort) abort_pend_d = 1'b1;
`ifdef DISPENSE_SEQ_TIMEOUT_EN
        to_cnt_d = 3'd7;
`endif
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (abort) abort_pend_d = 1'b1;
        if (dispense_sig) begin
          state_d = S_WAIT_LO;
        end
`ifdef DISPENSE_SEQ_TIMEOUT_EN
        else if (to_cnt_q == 3'd0) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q - 3'd1;
        end
`endif
      end
      S_WAIT_LO: begin
        if (abort) abort_pend_d = 1'b1;
        if (!dispense_sig) begin
          shot_end = 1'b1;
          if (shots_q != '0) shots_d = shots_q - CNT_W'(1);
          if (shots_q <= CNT_W'(1) || abort || abort_pend_q) begin
            state_d = S_DONE;
          end else if (gap_q != '0) begin
            gap_cnt_d = gap_q;
            state_d   = S_GAP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          state_d   = S_START;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign timer_start = (state_q == S_START);
  assign seq_done    = (state_q == S_DONE);
  assign shot_done   = shot_end;
  assign shots_left  = shots_q;
  assign timer_value = dur_q;
`ifdef DISPENSE_SEQ_TIMEOUT_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_dispense_sequencer.sv
module tb_dispense_sequencer;
  localparam int DUR_W = 31;
  localparam int GAP_W = 24;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [DUR_W-1:0] cmd_duration = '0;
  logic [GAP_W-1:0] cmd_gap = '0;
  logic [CNT_W-1:0] cmd_repeat = '0;
  logic             abort = 1'b0;
  logic [DUR_W-1:0] timer_value;
  logic             timer_start;
  logic             dispense_sig;
  logic             busy, shot_done, seq_done, fault;
  logic [CNT_W-1:0] shots_left;

  int vectors = 0;
  int miscompares = 0;

  dispense_sequencer #(.DUR_W(DUR_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .FPGA_CLK1_50(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_duration(cmd_duration), .cmd_gap(cmd_gap), .cmd_repeat(cmd_repeat),
    .abort(abort), .timer_value(timer_value), .timer_start(timer_start),
    .dispense_sig(dispense_sig), .busy(busy), .shot_done(shot_done),
    .seq_done(seq_done), .shots_left(shots_left), .fault(fault)
  );

  always #10 clk = ~clk;

  // Dispense timer model: rising edge of timer_start loads the duration,
  // output is high while the count is nonzero.
  logic [DUR_W-1:0] tcnt = '0;
  logic             ts_prev = 1'b0;
  logic             force_low = 1'b0;
  always @(posedge clk) begin
    ts_prev <= timer_start;
    if (timer_start && !ts_prev) tcnt <= timer_value;
    else if (tcnt != '0) tcnt <= tcnt - 1;
  end
  assign dispense_sig = (tcnt != '0) && !force_low;

  // Observations of one sequence, cycle numbers relative to the accept edge.
  int ts_q[$];
  int sd_q[$];
  int sl_after_sd[$];
  int seqd_cyc, ready_cyc, seqd_cnt, sl_at_seqd, sl_at_first_ts, min_low, busy_bad;
  logic fault_at_seqd, fault_k1;
  bit timed_out;

  // Reference: number of shots a command actually performs.
  function automatic int exp_shots(input int dur, input int rep, input int abort_at);
    if (dur == 0 || rep == 0) return 0;
    if (abort_at != 0 && abort_at < rep) return abort_at;
    return rep;
  endfunction

  task automatic run_seq(input int dur, input int gap, input int rep, input int abort_at);
    int w;
    int k;
    int low_run;
    bit prev_sd;
    ts_q.delete(); sd_q.delete(); sl_after_sd.delete();
    seqd_cyc = -1; ready_cyc = -1; seqd_cnt = 0; sl_at_seqd = -1;
    sl_at_first_ts = -1; min_low = 1000; busy_bad = 0; low_run = 0; prev_sd = 0;
    fault_at_seqd = 1'bx; fault_k1 = 1'bx;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
    cmd_valid = 1'b1;
    cmd_duration = DUR_W'(dur);
    cmd_gap = GAP_W'(gap);
    cmd_repeat = CNT_W'(rep);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    fault_k1 = fault;
    while (k < 3000) begin
      if (prev_sd) sl_after_sd.push_back(int'(shots_left));
      prev_sd = shot_done;
      if (timer_start) begin
        if (ts_q.size() > 0 && low_run < min_low) min_low = low_run;
        if (ts_q.size() == 0) sl_at_first_ts = int'(shots_left);
        ts_q.push_back(k);
        low_run = 0;
        if (abort_at != 0 && ts_q.size() == abort_at) abort = 1'b1;
      end else begin
        low_run++;
      end
      if (shot_done) sd_q.push_back(k);
      if (seq_done) begin
        seqd_cnt++;
        if (seqd_cyc < 0) begin
          seqd_cyc = k; sl_at_seqd = int'(shots_left); fault_at_seqd = fault;
        end
      end
      if (seqd_cyc >= 0 && cmd_ready) begin ready_cyc = k; break; end
      if (!busy || cmd_ready) busy_bad++;
      @(negedge clk);
      k++;
    end
    abort = 1'b0;
    timed_out = (ready_cyc < 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({timer_start, timer_value, shot_done, seq_done, shots_left, busy, fault} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ts=%b tv=%0d sd=%b qd=%b sl=%0d busy=%b fault=%b, want all 0",
               timer_start, timer_value, shot_done, seq_done, shots_left, busy, fault);
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_seq(10, 5, 3, 0);
    vectors++;
    if (timed_out || ts_q.size() != 3 || sd_q.size() != 3) begin
      miscompares++;
      $display("FAIL basic_counts: got to=%0b ts=%0d sd=%0d want to=0 ts=3 sd=3", timed_out, ts_q.size(), sd_q.size());
    end
    vectors++;
    if (sl_at_first_ts != 3) begin miscompares++; $display("FAIL basic_sl_start: got %0d want 3", sl_at_first_ts); end
    for (int i = 0; i < sl_after_sd.size() && i < 3; i++) begin
      vectors++;
      if (sl_after_sd[i] != 2 - i) begin
        miscompares++; $display("FAIL basic_sl_step%0d: got %0d want %0d", i, sl_after_sd[i], 2 - i);
      end
    end
    vectors++;
    if (ts_q.size() > 0 && ts_q[0] != 1) begin miscompares++; $display("FAIL basic_first_start: got %0d want 1", ts_q[0]); end
    for (int i = 0; i < sd_q.size() && i < ts_q.size(); i++) begin
      vectors++;
      if (sd_q[i] - ts_q[i] != 11) begin
        miscompares++; $display("FAIL basic_shot_len%0d: got %0d want 11", i, sd_q[i] - ts_q[i]);
      end
      if (i + 1 < ts_q.size()) begin
        vectors++;
        if (ts_q[i+1] - sd_q[i] != 6) begin
          miscompares++; $display("FAIL basic_gap%0d: got %0d want 6", i, ts_q[i+1] - sd_q[i]);
        end
      end
    end
    vectors++;
    if (seqd_cnt != 1 || sd_q.size() == 0 || seqd_cyc != sd_q[sd_q.size()-1] + 1) begin
      miscompares++; $display("FAIL basic_seq_done: got cnt=%0d cyc=%0d want one pulse after last shot", seqd_cnt, seqd_cyc);
    end
    vectors++;
    if (busy_bad != 0 || ready_cyc != seqd_cyc + 1) begin
      miscompares++; $display("FAIL basic_busy_ready: got busy_bad=%0d ready=%0d want 0 and %0d", busy_bad, ready_cyc, seqd_cyc + 1);
    end
  endtask

  task automatic test_zero();
    run_seq(10, 5, 0, 0);
    vectors++;
    if (ts_q.size() != 0 || sd_q.size() != 0) begin
      miscompares++; $display("FAIL zero_rep_pulses: got ts=%0d sd=%0d want 0 0", ts_q.size(), sd_q.size());
    end
    vectors++;
    if (seqd_cyc != 1 || ready_cyc != 2 || seqd_cnt != 1) begin
      miscompares++; $display("FAIL zero_rep_timing: got seq_done@%0d ready@%0d cnt=%0d want 1 2 1", seqd_cyc, ready_cyc, seqd_cnt);
    end
    run_seq(0, 3, 4, 0);
    vectors++;
    if (ts_q.size() != 0 || seqd_cyc != 1 || ready_cyc != 2) begin
      miscompares++; $display("FAIL zero_dur: got ts=%0d seq_done@%0d ready@%0d want 0 1 2", ts_q.size(), seqd_cyc, ready_cyc);
    end
  endtask

  task automatic test_abort();
    run_seq(20, 100, 4, 2);
    vectors++;
    if (timed_out || sd_q.size() != 2 || ts_q.size() != 2) begin
      miscompares++; $display("FAIL abort_shots: got to=%0b sd=%0d ts=%0d want 0 2 2", timed_out, sd_q.size(), ts_q.size());
    end
    vectors++;
    if (sd_q.size() == 2 && ts_q.size() == 2 && sd_q[1] - ts_q[1] != 21) begin
      miscompares++; $display("FAIL abort_shot2_len: got %0d want 21", sd_q[1] - ts_q[1]);
    end
    vectors++;
    if (sl_at_seqd != 2 || seqd_cnt != 1) begin
      miscompares++; $display("FAIL abort_done: got sl=%0d cnt=%0d want 2 1", sl_at_seqd, seqd_cnt);
    end
  endtask

  task automatic test_gap0();
    run_seq(6, 0, 2, 0);
    vectors++;
    if (ts_q.size() != 2 || sd_q.size() != 2) begin
      miscompares++; $display("FAIL gap0_shots: got ts=%0d sd=%0d want 2 2", ts_q.size(), sd_q.size());
    end
    vectors++;
    if (min_low < 1) begin miscompares++; $display("FAIL gap0_low: got %0d want >=1", min_low); end
    vectors++;
    if (ts_q.size() == 2 && sd_q.size() == 2 && ts_q[1] - sd_q[0] != 1) begin
      miscompares++; $display("FAIL gap0_restart: got %0d want 1", ts_q[1] - sd_q[0]);
    end
    vectors++;
    if (sl_at_seqd != 0) begin miscompares++; $display("FAIL gap0_sl: got %0d want 0", sl_at_seqd); end
  endtask

  task automatic test_random();
    int dur, gap, rep, ab, es;
    for (int it = 0; it < 12; it++) begin
      dur = $urandom_range(1, 15);
      gap = $urandom_range(0, 6);
      rep = $urandom_range(0, 4);
      ab  = (rep > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, rep) : 0;
      es  = exp_shots(dur, rep, ab);
      run_seq(dur, gap, rep, ab);
      vectors++;
      if (timed_out || ts_q.size() != es || sd_q.size() != es || seqd_cnt != 1) begin
        miscompares++;
        $display("FAIL rand%0d_counts: d=%0d g=%0d r=%0d a=%0d got to=%0b ts=%0d sd=%0d qd=%0d want ts=sd=%0d qd=1",
                 it, dur, gap, rep, ab, timed_out, ts_q.size(), sd_q.size(), seqd_cnt, es);
      end
      vectors++;
      if (sl_at_seqd != ((es == 0) ? 0 : rep - es)) begin
        miscompares++; $display("FAIL rand%0d_sl: got %0d want %0d", it, sl_at_seqd, (es == 0) ? 0 : rep - es);
      end
      for (int i = 0; i < sd_q.size() && i < ts_q.size(); i++) begin
        vectors++;
        if (sd_q[i] - ts_q[i] != dur + 1 || (i + 1 < ts_q.size() && ts_q[i+1] - sd_q[i] != gap + 1)) begin
          miscompares++; $display("FAIL rand%0d_spacing%0d: shot=%0d want %0d gap=%0d want %0d", it, i,
                                  sd_q[i] - ts_q[i], dur + 1, (i + 1 < ts_q.size()) ? ts_q[i+1] - sd_q[i] : -1, gap + 1);
        end
      end
      vectors++;
      if (seqd_cyc != ((es == 0) ? 1 : ((sd_q.size() > 0) ? sd_q[sd_q.size()-1] + 1 : -2))
          || ready_cyc != seqd_cyc + 1 || busy_bad != 0 || fault_at_seqd !== 1'b0) begin
        miscompares++; $display("FAIL rand%0d_end: seq_done@%0d ready@%0d busy_bad=%0d fault=%b", it,
                                seqd_cyc, ready_cyc, busy_bad, fault_at_seqd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int idle_bad;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_duration = 30; cmd_gap = 3; cmd_repeat = 2;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (!timer_start && w < 20) begin @(negedge clk); w++; end
    repeat (4) @(negedge clk);
    vectors++;
    if (!(busy && dispense_sig)) begin
      miscompares++; $display("FAIL rstmid_setup: got busy=%b sig=%b want 1 1", busy, dispense_sig);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({timer_start, timer_value, shot_done, seq_done, shots_left, busy, fault} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: got ts=%b tv=%0d sd=%b qd=%b sl=%0d busy=%b fault=%b, want all 0",
               timer_start, timer_value, shot_done, seq_done, shots_left, busy, fault);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (shot_done || busy || timer_start || seq_done) idle_bad++;
    end
    vectors++;
    if (idle_bad != 0) begin miscompares++; $display("FAIL rstmid_idle: got %0d active cycles want 0", idle_bad); end
    run_seq(5, 2, 2, 0);
    vectors++;
    if (timed_out || ts_q.size() != 2 || sd_q.size() != 2 || sl_at_seqd != 0) begin
      miscompares++; $display("FAIL rstmid_after: got ts=%0d sd=%0d sl=%0d want 2 2 0", ts_q.size(), sd_q.size(), sl_at_seqd);
    end
  endtask

`ifdef DISPENSE_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    force_low = 1'b1;
    run_seq(10, 0, 3, 0);
    force_low = 1'b0;
    vectors++;
    if (timed_out || ts_q.size() != 1 || sd_q.size() != 0) begin
      miscompares++; $display("FAIL timeout_shots: got ts=%0d sd=%0d want 1 0", ts_q.size(), sd_q.size());
    end
    vectors++;
    if (ts_q.size() > 0 && seqd_cyc - ts_q[0] != 9) begin
      miscompares++; $display("FAIL timeout_latency: got %0d want 9", seqd_cyc - ts_q[0]);
    end
    vectors++;
    if (fault_at_seqd !== 1'b1) begin miscompares++; $display("FAIL timeout_fault: got %b want 1", fault_at_seqd); end
    repeat (15) @(negedge clk);
    run_seq(4, 0, 1, 0);
    vectors++;
    if (fault_k1 !== 1'b0) begin miscompares++; $display("FAIL timeout_clear: got %b want 0", fault_k1); end
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_abort();
    test_gap0();
    test_random();
    test_reset_mid();
`ifdef DISPENSE_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
